// File: rtl/mac_vec.sv
// Pipelined multi-lane fixed-point dot-product MAC with packet framing and valid/ready flow control.
// Define MAC_VEC_SAT_EN to clamp overflowing alignment/accumulate steps; the default build wraps.
module mac_vec #(
  parameter int lanes_p    = 4,
  parameter int int_in_p   = 1,
  parameter int frac_in_p  = 11,
  parameter int int_out_p  = 10,
  parameter int frac_out_p = 22
) (
  input  logic                                      clk_i,
  input  logic                                      reset_ni,
  input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]   a_i,
  input  logic [lanes_p*(int_in_p+frac_in_p)-1:0]   b_i,
  input  logic                                      last_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic [int_out_p+frac_out_p-1:0]           data_o,
  output logic                                      ovf_o
);

  localparam int in_w      = int_in_p + frac_in_p;
  localparam int prod_w    = 2 * in_w;
  localparam int lane_bits = $clog2(lanes_p);
  localparam int sum_w     = prod_w + lane_bits;
  localparam int out_w     = int_out_p + frac_out_p;
  localparam int shift     = (frac_out_p >= 2*frac_in_p) ? frac_out_p - 2*frac_in_p : 0;
  localparam int align_w   = sum_w + shift;
  localparam int wide_w    = (align_w > out_w) ? align_w : out_w;

  generate
    if (frac_out_p < 2*frac_in_p) begin : g_bad_frac
      $error("mac_vec: frac_out_p must be at least 2*frac_in_p");
    end
    if (lanes_p < 1 || lanes_p > 16) begin : g_bad_lanes
      $error("mac_vec: lanes_p must be in 1..16");
    end
  endgenerate

  logic                      en;
  logic signed [prod_w-1:0]  prod [lanes_p];
  logic signed [sum_w-1:0]   sum_c;
  logic signed [sum_w-1:0]   sum_r;
  logic                      s1_valid_r;
  logic                      s1_last_r;
  logic signed [wide_w-1:0]  wide_c;
  logic                      align_ovf;
  logic signed [out_w-1:0]   aligned;
  logic        [out_w:0]     acc_sum_c;
  logic                      acc_ovf;
  logic signed [out_w-1:0]   step_c;
  logic                      step_ovf;
  logic signed [out_w-1:0]   acc_r;
  logic                      ovf_r;

  // The whole pipeline advances only when the output register is free or being drained.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  for (genvar gi = 0; gi < lanes_p; gi++) begin : g_lane
    logic signed [in_w-1:0] a_lane;
    logic signed [in_w-1:0] b_lane;
    assign a_lane   = $signed(a_i[gi*in_w +: in_w]);
    assign b_lane   = $signed(b_i[gi*in_w +: in_w]);
    assign prod[gi] = a_lane * b_lane;
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < lanes_p; k++) begin
      sum_c = sum_c + sum_w'(prod[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sum_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else if (en) begin
      sum_r      <= sum_c;
      s1_valid_r <= valid_i;
      s1_last_r  <= last_i;
    end
  end

  // Align the product sum to the output binary point; bits above the output MSB must all match the sign.
  assign wide_c    = wide_w'(sum_r) <<< shift;
  assign align_ovf = !((&wide_c[wide_w-1:out_w-1]) || !(|wide_c[wide_w-1:out_w-1]));

  // Accumulate with one guard bit so signed overflow shows as disagreeing top two bits.
  assign acc_sum_c = {acc_r[out_w-1], acc_r} + {aligned[out_w-1], aligned};
  assign acc_ovf   = acc_sum_c[out_w] ^ acc_sum_c[out_w-1];
  assign step_ovf  = align_ovf | acc_ovf;

`ifdef MAC_VEC_SAT_EN
  localparam logic signed [out_w-1:0] max_val = {1'b0, {(out_w-1){1'b1}}};
  localparam logic signed [out_w-1:0] min_val = {1'b1, {(out_w-1){1'b0}}};

  always_comb begin
    aligned = wide_c[out_w-1:0];
    if (align_ovf) begin
      aligned = wide_c[wide_w-1] ? min_val : max_val;
    end
    step_c = acc_sum_c[out_w-1:0];
    if (acc_ovf) begin
      step_c = acc_sum_c[out_w] ? min_val : max_val;
    end
  end
`else
  assign aligned = wide_c[out_w-1:0];
  assign step_c  = acc_sum_c[out_w-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
      ovf_o   <= 1'b0;
    end else if (en) begin
      valid_o <= 1'b0;
      if (s1_valid_r) begin
        if (s1_last_r) begin
          data_o  <= step_c;
          ovf_o   <= ovf_r | step_ovf;
          valid_o <= 1'b1;
          acc_r   <= '0;
          ovf_r   <= 1'b0;
        end else begin
          acc_r <= step_c;
          ovf_r <= ovf_r | step_ovf;
        end
      end
    end
  end

endmodule
